// File: rtl/uart_sender_core.sv
// -----------------------------------------------------------------------------
// uart_sender_core
//
// Drains a block of 10-bit pixel words from the SDRAM read-side FIFO and sends
// the upper 8 bits of each word as one 8N1 UART byte on GPIO[0]. A press on
// KEY[2] starts a block. The block length is taken from SW when the key is seen.
// After the block the core waits for the key to be released before it re-arms.
//
// Ports
//   CLOCK_50      in   system clock; all logic runs on its rising edge
//   reset         in   asynchronous, active-high reset
//   KEY[3:0]      in   push buttons, active-low; only KEY[2] (start) is used
//   SW[9:0]       in   number of words to send, latched at start
//   sdram_rddata  in   FIFO read data, valid the cycle after an sdram_rd_clk pulse
//   sdram_load    out  one-cycle pulse that rewinds/reloads the FIFO read side
//   sdram_rd_clk  out  one-cycle read strobe, one per word
//   GPIO[35:0]    io   GPIO[0] = UART TX (idle high); GPIO[35:1] high-Z
// -----------------------------------------------------------------------------
module uart_sender_core #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    input  logic [9:0]  sdram_rddata,
    output logic        sdram_load,
    output logic        sdram_rd_clk,
    inout  wire  [35:0] GPIO
);

    // Encoding is observed from outside, so the values are fixed.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_READ    = 4'd2,
        ST_CAPTURE = 4'd3,
        ST_START   = 4'd4,
        ST_DATA    = 4'd5,
        ST_STOP    = 4'd6,
        ST_DONE    = 4'd7
    } state_t;

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           is_state;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [9:0]       words_left_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             load_q;
    logic             rd_q;

    logic             baud_last;
    logic             start_req;
    logic             key_released;
    logic [2:0]       bit_idx_d;

    // Comparisons against explicit constants keep an undriven (X) key from
    // being mistaken for a press or a release.
    assign start_req    = (KEY[2] == 1'b0);
    assign key_released = (KEY[2] == 1'b1);
    assign baud_last    = (baud_cnt_q == BAUD_LAST);
    assign bit_idx_d    = bit_idx_q + 3'd1;

    // The strobes and the TX level are registered and updated together with
    // the state. Each output therefore changes in the same cycle as the state
    // it belongs to: sdram_load is high for the whole LOAD cycle, sdram_rd_clk
    // for the whole READ cycle, and TX is low for the whole START period.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            is_state     <= ST_IDLE;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            words_left_q <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            load_q       <= 1'b0;
            rd_q         <= 1'b0;
        end else begin
            load_q     <= 1'b0;
            rd_q       <= 1'b0;
            baud_cnt_q <= baud_cnt_q + 1'b1;

            unique case (is_state)
                ST_IDLE: begin
                    tx_q       <= 1'b1;
                    baud_cnt_q <= '0;
                    if (start_req) begin
                        words_left_q <= SW;
                        if (SW == 10'd0) begin
                            is_state <= ST_DONE;
                        end else begin
                            is_state <= ST_LOAD;
                            load_q   <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    baud_cnt_q <= '0;
                    is_state   <= ST_READ;
                    rd_q       <= 1'b1;
                end

                // The FIFO presents the word during CAPTURE, one cycle after
                // the strobe.
                ST_READ: begin
                    baud_cnt_q <= '0;
                    is_state   <= ST_CAPTURE;
                end

                ST_CAPTURE: begin
                    shift_q      <= sdram_rddata[9:2];
                    words_left_q <= words_left_q - 10'd1;
                    bit_idx_q    <= '0;
                    baud_cnt_q   <= '0;
                    tx_q         <= 1'b0;
                    is_state     <= ST_START;
                end

                ST_START: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= shift_q[0];
                        is_state   <= ST_DATA;
                    end
                end

                // The level for the next bit is loaded when the current bit
                // ends. TX therefore has no mux between the counter and the pin.
                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q     <= 1'b1;
                            is_state <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_d;
                            tx_q      <= shift_q[bit_idx_d];
                        end
                    end
                end

                // Later words go straight back to READ. The FIFO read pointer
                // is only rewound once per block.
                ST_STOP: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        if (words_left_q == 10'd0) begin
                            is_state <= ST_DONE;
                        end else begin
                            is_state <= ST_READ;
                            rd_q     <= 1'b1;
                        end
                    end
                end

                // A block restarts only after the key is released. A held key
                // does not send the block again.
                ST_DONE: begin
                    tx_q       <= 1'b1;
                    baud_cnt_q <= '0;
                    if (key_released) begin
                        is_state <= ST_IDLE;
                    end
                end

                default: begin
                    tx_q       <= 1'b1;
                    baud_cnt_q <= '0;
                    is_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign sdram_load   = load_q;
    assign sdram_rd_clk = rd_q;
    assign GPIO         = {{35{1'bz}}, tx_q};

    // The design does not use these input bits.
    logic unused_inputs;
    assign unused_inputs = ^{KEY[3], KEY[1:0], sdram_rddata[1:0]};

endmodule

// File: tb/tb_uart_sender_core.sv
// -----------------------------------------------------------------------------
// tb_uart_sender_core
//
// Scoreboard bench for uart_sender_core.
//
// A FIFO model answers every read strobe with a word. It pushes the byte that
// the word should produce into a queue. A separate UART monitor decodes the TX
// line cycle by cycle, pops the queue and compares each frame. The main
// process drives the key and switches, and checks transfer length, strobe
// counts, DONE/IDLE handshaking and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_uart_sender_core;

    localparam int CPB = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [9:0]  sdram_rddata;
    logic        sdram_load;
    logic        sdram_rd_clk;
    wire  [35:0] gpio;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int  load_cnt = 0;
    int  rd_cnt = 0;
    int  tx_low_seen = 0;
    int  frames_done = 0;
    bit  first_fixed = 1'b0;

    uart_sender_core #(
        .CLK_FREQ    (50000000),
        .BAUD        (115200),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .KEY         (KEY),
        .SW          (SW),
        .sdram_rddata(sdram_rddata),
        .sdram_load  (sdram_load),
        .sdram_rd_clk(sdram_rd_clk),
        .GPIO        (gpio)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int tx();
        return (gpio[0] === 1'b1) ? 1 : 0;
    endfunction

    function automatic int st();
        return int'(dut.is_state);
    endfunction

    // Activity counters. They are sampled on the falling edge, and each count
    // is the number of cycles a signal was high (or low, for TX).
    initial begin
        forever begin
            @(negedge clk);
            if (sdram_load === 1'b1)   load_cnt++;
            if (sdram_rd_clk === 1'b1) rd_cnt++;
            if (gpio[0] !== 1'b1)      tx_low_seen++;
        end
    end

    // FIFO model. A word answers each read strobe and is held for the
    // following cycle. At other times the data bus carries garbage.
    initial begin : fifo_model
        logic [9:0] w;
        int hold;
        hold = 0;
        sdram_rddata = 10'h000;
        forever begin
            @(negedge clk);
            if (sdram_rd_clk === 1'b1) begin
                if (first_fixed) w = 10'b1010_0101_11;
                else             w = 10'($urandom);
                first_fixed = 1'b0;
                sdram_rddata = w;
                exp_q.push_back(8'(w / 4));
                hold = 1;
            end else if (hold > 0) begin
                hold--;
            end else begin
                sdram_rddata = 10'($urandom);
            end
        end
    end

    // UART monitor. It detects a start bit, checks every cycle of the
    // 10-bit frame against the expected level, and samples mid-bit to
    // rebuild the byte.
    initial begin : monitor
        int phase;
        int bad;
        int bi;
        logic [7:0] expb;
        logic [7:0] got;
        logic eb;
        phase = -1;
        bad = 0;
        expb = '0;
        got = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                phase = -1;
            end else begin
                if (phase < 0 && gpio[0] === 1'b0) begin
                    check("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                    expb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                    phase = 0;
                    bad = 0;
                    got = '0;
                end
                if (phase >= 0) begin
                    bi = phase / CPB;
                    if (bi == 0)      eb = 1'b0;
                    else if (bi == 9) eb = 1'b1;
                    else              eb = expb[bi-1];
                    if (gpio[0] !== eb) bad++;
                    if (bi >= 1 && bi <= 8 && (phase % CPB) == CPB / 2)
                        got[bi-1] = gpio[0];
                    phase++;
                    if (phase == 10 * CPB) begin
                        check("frame_byte", int'(got), int'(expb));
                        check("frame_bit_timing", bad, 0);
                        frames_done++;
                        phase = -1;
                    end
                end
            end
        end
    end

    task automatic run_transfer(input int n, input bit sw_change);
        int cyc;
        int guard;
        int exp_cyc;
        int held_ok;
        @(negedge clk);
        load_cnt = 0;
        rd_cnt = 0;
        tx_low_seen = 0;
        frames_done = 0;
        SW = 10'(n);
        KEY[2] = 1'b0;
        exp_cyc = (n == 0) ? 0 : 1 + n * (2 + 10 * CPB);
        cyc = 0;
        guard = 0;
        @(negedge clk);
        while (st() != 7 && guard < exp_cyc + 200) begin
            if (st() != 0) cyc++;
            if (sw_change && guard == 20) SW = 10'd2;
            @(negedge clk);
            guard++;
        end
        check("done_reached", st(), 7);
        check("transfer_cycles", cyc, exp_cyc);
        held_ok = 1;
        repeat (4) begin
            @(negedge clk);
            if (st() != 7) held_ok = 0;
        end
        check("done_held_while_key_down", held_ok, 1);
        check("load_pulse_cycles", load_cnt, (n > 0) ? 1 : 0);
        check("rd_pulse_cycles", rd_cnt, n);
        check("frames_sent", frames_done, n);
        check("scoreboard_empty", exp_q.size(), 0);
        if (n == 0) check("tx_stayed_high", tx_low_seen, 0);
        KEY[2] = 1'b1;
        @(negedge clk);
        check("idle_after_release", st(), 0);
    endtask

    task automatic reset_mid_data();
        int guard;
        @(negedge clk);
        first_fixed = 1'b1;
        SW = 10'd3;
        KEY[2] = 1'b0;
        guard = 0;
        while (!(st() == 5 && gpio[0] === 1'b0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("reached_data_low_bit", (st() == 5 && gpio[0] === 1'b0) ? 1 : 0, 1);
        #1 reset = 1'b1;
        #1;
        check("async_reset_state", st(), 0);
        check("async_reset_tx", tx(), 1);
        check("async_reset_load", int'(sdram_load), 0);
        check("async_reset_rd", int'(sdram_rd_clk), 0);
        KEY[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        load_cnt = 0;
        rd_cnt = 0;
        tx_low_seen = 0;
        repeat (20) @(negedge clk);
        check("post_reset_no_load", load_cnt, 0);
        check("post_reset_no_rd", rd_cnt, 0);
        check("post_reset_tx_high", tx_low_seen, 0);
        check("post_reset_idle", st(), 0);
    endtask

    initial begin
        reset = 1'b1;
        KEY = 4'hF;
        SW = 10'd0;
        repeat (3) @(negedge clk);
        check("reset_state", st(), 0);
        check("reset_tx", tx(), 1);
        check("reset_load", int'(sdram_load), 0);
        check("reset_rd", int'(sdram_rd_clk), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_with_key_up", st(), 0);

        // Eight words, known first word 0xA5, SW changed mid-transfer.
        first_fixed = 1'b1;
        run_transfer(8, 1'b1);

        // A zero-length block goes straight to DONE.
        run_transfer(0, 1'b0);

        // Random block lengths and random pixel words.
        for (int i = 0; i < 5; i++) begin
            run_transfer(int'($urandom_range(1, 5)), 1'b0);
        end

        reset_mid_data();

        // A normal transfer must work after the abort.
        run_transfer(int'($urandom_range(2, 4)), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
